m3_sopc_led_pwm: RTL and testbench
==================================

M3_SOPC_LED_PWM -- requirements
Module: m3_sopc_led_pwm

Interface
REQ-001 Parameter TICK_DIV, default 195: clocks per PWM step; legal range 1..65535.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-007 writedata  input  32  write data; only bits [7:0] are used.
REQ-008 readdata  output  32  read data; zero-wait-state, combinational from address; bits [31:8]=0.
REQ-009 led_in  input  8  LED on/off pattern from the upstream PIO out_port.
REQ-010 led_out  output  8  PWM-dimmed LED drive; registered; 1 = LED on.

Function
REQ-011 Register map SHALL be: addr0 CTRL (bit0 enable, bit1 fade_en, R/W); addr1 BRIGHT[7:0] (R/W); addr2 FADE_STEP[7:0] (R/W); addr3 STATUS[7:0] (read-only, per-channel ramping flag; writes ignored).
REQ-012 Tick counter SHALL count 0..TICK_DIV-1 and wrap; a tick is the cycle where it equals TICK_DIV-1.
REQ-013 pwm_cnt (8-bit) SHALL increment on each tick, wrapping 255->0; a frame end is the tick on which pwm_cnt is 255.
REQ-014 Each channel i SHALL hold level[i] (8-bit); target[i] = BRIGHT if led_in[i]=1, else 0.
REQ-015 At a frame end with fade_en=0, level[i] SHALL load target[i].
REQ-016 At a frame end with fade_en=1, level[i] SHALL move toward target[i] by FADE_STEP and saturate exactly at target[i]; no overshoot and no 8-bit wrap.
REQ-017 FADE_STEP=0 SHALL behave as step 1.
REQ-018 STATUS[i] SHALL be 1 whenever level[i] != target[i].
REQ-019 led_out[i] SHALL be registered as enable & (level[i] > pwm_cnt): level 0 is always off; level 255 is on for 255 of 256 steps.
REQ-020 BRIGHT, FADE_STEP and led_in changes SHALL affect level only at the next frame end; a mid-frame change SHALL NOT alter the current frame's comparisons.
REQ-021 A register write SHALL take effect on the clock edge of the write; a read in the same cycle SHALL return the old value.
REQ-022 While enable=0: tick counter, pwm_cnt and all level[i] SHALL be held at 0, and led_out SHALL be 0 from the first edge after CTRL.enable is cleared.
REQ-023 On 0->1 of enable, counting SHALL start from tick=0, pwm_cnt=0, with levels at 0; with fade_en=1 the LEDs ramp up from off.
REQ-024 led_in SHALL be sampled synchronously; it comes from the same clock domain, so no synchronizer is required.

Reset
REQ-025 On reset_n=0, asynchronously: CTRL=0, BRIGHT=0xFF, FADE_STEP=0x01, tick=0, pwm_cnt=0, level[all]=0, led_out=0.
REQ-026 After reset: STATUS=0x00 (targets 0 because BRIGHT is ignored until enable); readdata follows address immediately.
REQ-027 Reset asserted mid-frame or mid-ramp SHALL abort all activity; after release the block SHALL be idle as in REQ-025.

Verification
REQ-028 TICK_DIV=2, write CTRL=1, BRIGHT=0x80, led_in=0x01 -> after the first frame end (512 clocks), led_out[0] is high for 128 of every 256 steps (256 clocks per 512); other bits are 0.
REQ-029 Set fade_en=1, FADE_STEP=0x30, BRIGHT=0xFF, led_in 0x00->0xFF -> levels step 0x30, 0x60, 0x90, 0xC0, 0xF0, 0xFF on successive frame ends; STATUS=0xFF until the 0xFF frame, then 0x00.
REQ-030 At level 0xFF, drop led_in to 0x00 with FADE_STEP=0xF0 -> levels go 0x0F, then 0x00 (no wrap); led_out then stays 0.
REQ-031 Write BRIGHT=0x10 mid-frame -> the current frame keeps the old duty; the new duty applies from the frame after the next frame end.
REQ-032 Clear enable mid-frame -> led_out=0x00 on the next edge; re-enable -> pwm_cnt restarts at 0 and levels restart at 0.
REQ-033 Assert reset_n during a ramp -> all outputs 0 immediately; readback gives CTRL=0, BRIGHT=0xFF, FADE_STEP=0x01, STATUS=0.

Source files
------------

// File: rtl/m3_sopc_led_pwm.sv
// Avalon-MM slave that PWM-dims an 8-bit LED pattern, with optional per-channel
// brightness fading applied at PWM frame boundaries.
module m3_sopc_led_pwm #(
    parameter int unsigned TICK_DIV = 195
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  led_in,
    output logic [7:0]  led_out
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 32'd1);

    logic [1:0]       ctrl_r;
    logic [7:0]       bright_r;
    logic [7:0]       fade_step_r;
    logic [15:0]      tick_r;
    logic [7:0]       pwm_cnt_r;
    logic [7:0][7:0]  level_r;
    logic [7:0]       led_out_r;

    logic             wr_s;
    logic [1:0]       ctrl_next_s;
    logic             run_s;
    logic             tick_s;
    logic             frame_end_s;
    logic [7:0][7:0]  target_s;
    logic [7:0]       status_s;
    logic [7:0][7:0]  level_next_s;
    logic [7:0]       led_next_s;
    logic             unused_s;

    // Move cur toward tgt by step (0 treated as 1), landing exactly on tgt.
    function automatic logic [7:0] fade_next(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
        logic [8:0] step_eff;
        logic [8:0] diff;
        step_eff = (step == 8'd0) ? 9'd1 : {1'b0, step};
        if (cur < tgt) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            return (diff <= step_eff) ? tgt : 8'({1'b0, cur} + step_eff);
        end else if (cur > tgt) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            return (diff <= step_eff) ? tgt : 8'({1'b0, cur} - step_eff);
        end else begin
            return cur;
        end
    endfunction

    assign wr_s        = chipselect & ~write_n;
    assign unused_s    = ^writedata[31:8];
    // Counting runs only when enable is set both before and after this edge,
    // so a fresh enable starts from tick 0 and a clear zeroes state at once.
    assign run_s       = ctrl_r[0] & ctrl_next_s[0];
    assign tick_s      = run_s & (tick_r == TICK_LAST);
    assign frame_end_s = tick_s & (pwm_cnt_r == 8'hFF);
    assign led_out     = led_out_r;

    // Next CTRL value, used so led_out drops on the same edge as the clear.
    always_comb begin
        ctrl_next_s = ctrl_r;
        if (wr_s && (address == 2'd0)) begin
            ctrl_next_s = writedata[1:0];
        end else begin
            ctrl_next_s = ctrl_r;
        end
    end

    // Per-channel target, status, next level and next LED drive.
    always_comb begin
        target_s     = '0;
        status_s     = 8'd0;
        level_next_s = '0;
        led_next_s   = 8'd0;
        for (int i = 0; i < 8; i++) begin
            target_s[i] = (ctrl_r[0] && led_in[i]) ? bright_r : 8'd0;
            status_s[i] = (level_r[i] != target_s[i]);
            if (!run_s) begin
                level_next_s[i] = 8'd0;
            end else if (frame_end_s) begin
                if (ctrl_r[1]) begin
                    level_next_s[i] = fade_next(level_r[i], target_s[i], fade_step_r);
                end else begin
                    level_next_s[i] = target_s[i];
                end
            end else begin
                level_next_s[i] = level_r[i];
            end
            led_next_s[i] = ctrl_next_s[0] & (level_r[i] > pwm_cnt_r);
        end
    end

    // Zero-wait-state register readback.
    always_comb begin
        case (address)
            2'd0:    readdata = {30'd0, ctrl_r};
            2'd1:    readdata = {24'd0, bright_r};
            2'd2:    readdata = {24'd0, fade_step_r};
            2'd3:    readdata = {24'd0, status_s};
            default: readdata = 32'd0;
        endcase
    end

    // Software-visible registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_r      <= 2'd0;
            bright_r    <= 8'hFF;
            fade_step_r <= 8'h01;
        end else begin
            ctrl_r <= ctrl_next_s;
            if (wr_s && (address == 2'd1)) begin
                bright_r <= writedata[7:0];
            end
            if (wr_s && (address == 2'd2)) begin
                fade_step_r <= writedata[7:0];
            end
        end
    end

    // Tick prescaler and PWM step counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_r    <= 16'd0;
            pwm_cnt_r <= 8'd0;
        end else if (!run_s) begin
            tick_r    <= 16'd0;
            pwm_cnt_r <= 8'd0;
        end else begin
            if (tick_r == TICK_LAST) begin
                tick_r <= 16'd0;
            end else begin
                tick_r <= tick_r + 16'd1;
            end
            if (tick_s) begin
                pwm_cnt_r <= pwm_cnt_r + 8'd1;
            end
        end
    end

    // Channel levels and registered LED drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r   <= '0;
            led_out_r <= 8'd0;
        end else begin
            level_r   <= level_next_s;
            led_out_r <= led_next_s;
        end
    end

endmodule

// File: tb/tb_m3_sopc_led_pwm.sv
// Self-checking bench for m3_sopc_led_pwm: directed scenarios plus random traffic
// compared against a frame-level arithmetic model of the LED dimmer.
module tb_m3_sopc_led_pwm;

    localparam int TD    = 2;
    localparam int FRAME = TD * 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  led_in = 8'd0;
    logic [7:0]  led_out;

    int checks = 0;
    int passed = 0;

    logic       m_en, m_fade;
    logic [7:0] m_bright, m_step;
    int         m_cyc;
    int         m_lvl [8];
    logic [7:0] m_led;
    int         acc0, acc1;

    m3_sopc_led_pwm #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .led_in(led_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_en = 1'b0; m_fade = 1'b0; m_bright = 8'hFF; m_step = 8'h01;
        m_cyc = 0; m_led = 8'd0;
        for (int i = 0; i < 8; i++) m_lvl[i] = 0;
    endtask

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            int tgt;
            tgt = (m_en && led_in[i]) ? int'(m_bright) : 0;
            s[i] = (m_lvl[i] != tgt);
        end
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_fade, m_en};
            2'd1:    return {24'd0, m_bright};
            2'd2:    return {24'd0, m_step};
            default: return {24'd0, m_status()};
        endcase
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then sample.
    task automatic cyc();
        logic en_n, fade_n;
        logic [7:0] bright_n, step_n;
        int pwm, tgt, d, s;
        bit run, fe;
        @(posedge clk);
        en_n = m_en; fade_n = m_fade; bright_n = m_bright; step_n = m_step;
        if (chipselect && !write_n) begin
            case (address)
                2'd0: begin en_n = writedata[0]; fade_n = writedata[1]; end
                2'd1: bright_n = writedata[7:0];
                2'd2: step_n = writedata[7:0];
                default: ;
            endcase
        end
        run = m_en && en_n;
        pwm = (m_cyc / TD) % 256;
        fe  = run && ((m_cyc % FRAME) == FRAME - 1);
        for (int i = 0; i < 8; i++) m_led[i] = en_n && (m_lvl[i] > pwm);
        if (!run) begin
            m_cyc = 0;
            for (int i = 0; i < 8; i++) m_lvl[i] = 0;
        end else begin
            if (fe) begin
                for (int i = 0; i < 8; i++) begin
                    tgt = led_in[i] ? int'(m_bright) : 0;
                    if (m_fade) begin
                        s = (m_step == 8'd0) ? 1 : int'(m_step);
                        d = tgt - m_lvl[i];
                        if (d > s) m_lvl[i] = m_lvl[i] + s;
                        else if (d < -s) m_lvl[i] = m_lvl[i] - s;
                        else m_lvl[i] = tgt;
                    end else begin
                        m_lvl[i] = tgt;
                    end
                end
            end
            m_cyc = m_cyc + 1;
        end
        m_en = en_n; m_fade = fade_n; m_bright = bright_n; m_step = step_n;
        #1;
        acc0 = acc0 + int'(led_out[0]);
        acc1 = acc1 + int'(led_out[1]);
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        address = a;
        writedata = $urandom();
        writedata[7:0] = d;
        chipselect = 1'b1; write_n = 1'b0;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic align();
        while ((m_cyc % FRAME) != 0) cyc();
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h0, 32'hFF, 32'h01, 32'h00};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (led_out !== 8'h00) $display("FAIL reset_led_out: got %h expected 00", led_out);
        else passed++;
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            checks++;
            if (readdata !== exp_rd[a]) $display("FAIL reset_read[%0d]: got %h expected %h", a, readdata, exp_rd[a]);
            else passed++;
        end
    endtask

    task automatic test_static_duty();
        led_in = 8'h01;
        wr(2'd1, 8'h80);
        wr(2'd0, 8'h01);
        acc0 = 0; acc1 = 0;
        run_n(FRAME);
        checks++;
        if (acc0 !== 0) $display("FAIL static_first_frame_dark: got %0d expected 0", acc0);
        else passed++;
        acc0 = 0; acc1 = 0;
        run_n(FRAME);
        checks++;
        if (acc0 !== 256 || acc1 !== 0) $display("FAIL static_duty: got %0d/%0d expected 256/0", acc0, acc1);
        else passed++;
        acc0 = 0; acc1 = 0;
        run_n(10);
        led_in = 8'h03;
        align();
        checks++;
        if (acc1 !== 0) $display("FAIL led_in_mid_frame: got %0d expected 0", acc1);
        else passed++;
        acc0 = 0; acc1 = 0;
        run_n(FRAME);
        checks++;
        if (acc0 !== 256 || acc1 !== 256) $display("FAIL led_in_next_frame: got %0d/%0d expected 256/256", acc0, acc1);
        else passed++;
    endtask

    task automatic test_fade_up();
        logic [7:0] exp_lv [6];
        int expd;
        exp_lv = '{8'h30, 8'h60, 8'h90, 8'hC0, 8'hF0, 8'hFF};
        wr(2'd0, 8'h00);
        led_in = 8'h00;
        wr(2'd2, 8'h30);
        wr(2'd1, 8'hFF);
        wr(2'd0, 8'h03);
        led_in = 8'hFF;
        for (int f = 0; f < 7; f++) begin
            acc0 = 0;
            run_n(FRAME);
            expd = (f == 0) ? 0 : int'(exp_lv[f - 1]) * TD;
            checks++;
            if (acc0 !== expd) $display("FAIL fade_up_duty[%0d]: got %0d expected %0d", f, acc0, expd);
            else passed++;
            if (f < 6) begin
                address = 2'd3;
                #1;
                checks++;
                if (readdata !== ((f < 5) ? 32'hFF : 32'h00))
                    $display("FAIL fade_up_status[%0d]: got %h expected %h", f, readdata, (f < 5) ? 32'hFF : 32'h00);
                else passed++;
            end
        end
    endtask

    task automatic test_fade_down();
        int exp_d [3];
        exp_d = '{8'h0F * TD, 0, 0};
        led_in = 8'h00;
        wr(2'd2, 8'hF0);
        align();
        for (int f = 0; f < 3; f++) begin
            acc0 = 0;
            run_n(FRAME);
            checks++;
            if (acc0 !== exp_d[f]) $display("FAIL fade_down_duty[%0d]: got %0d expected %0d", f, acc0, exp_d[f]);
            else passed++;
        end
        address = 2'd3;
        #1;
        checks++;
        if (readdata !== 32'h00) $display("FAIL fade_down_status: got %h expected 00", readdata);
        else passed++;
    endtask

    task automatic test_mid_frame_bright();
        wr(2'd0, 8'h00);
        led_in = 8'h01;
        wr(2'd1, 8'h80);
        wr(2'd0, 8'h01);
        run_n(FRAME);
        acc0 = 0;
        run_n(100);
        address = 2'd1; writedata = 32'h0000_0010; chipselect = 1'b1; write_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'h80) $display("FAIL write_cycle_read_old: got %h expected 80", readdata);
        else passed++;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
        #1;
        checks++;
        if (readdata !== 32'h10) $display("FAIL bright_readback: got %h expected 10", readdata);
        else passed++;
        align();
        checks++;
        if (acc0 !== 256) $display("FAIL bright_mid_frame_old_duty: got %0d expected 256", acc0);
        else passed++;
        acc0 = 0;
        run_n(FRAME);
        checks++;
        if (acc0 !== 32) $display("FAIL bright_new_duty: got %0d expected 32", acc0);
        else passed++;
    endtask

    task automatic test_disable();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < FRAME && !seen; k++) begin
            cyc();
            seen = led_out[0];
        end
        checks++;
        if (!seen) $display("FAIL disable_wait_led_on: got 0 expected 1");
        else passed++;
        wr(2'd0, 8'h00);
        checks++;
        if (led_out !== 8'h00) $display("FAIL disable_led_off: got %h expected 00", led_out);
        else passed++;
        acc0 = 0;
        run_n(50);
        address = 2'd3;
        #1;
        checks++;
        if (acc0 !== 0 || readdata !== 32'h0) $display("FAIL disabled_idle: got %0d/%h expected 0/00", acc0, readdata);
        else passed++;
        wr(2'd0, 8'h01);
        acc0 = 0;
        run_n(FRAME);
        checks++;
        if (acc0 !== 0) $display("FAIL reenable_dark_frame: got %0d expected 0", acc0);
        else passed++;
        acc0 = 0;
        run_n(FRAME);
        checks++;
        if (acc0 !== 32) $display("FAIL reenable_duty: got %0d expected 32", acc0);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] d;
        wr(2'd0, 8'h01);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) led_in = 8'($urandom());
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                d = 8'($urandom());
                if (address == 2'd0 && $urandom_range(0, 7) != 0) d[0] = 1'b1;
                writedata = $urandom();
                writedata[7:0] = d;
                chipselect = 1'b1; write_n = 1'b0;
            end
            #1;
            checks++;
            if (readdata !== m_read(address)) $display("FAIL rand_read[%0d] a=%0d: got %h expected %h", k, address, readdata, m_read(address));
            else passed++;
            cyc();
            chipselect = 1'b0; write_n = 1'b1;
            checks++;
            if (led_out !== m_led) $display("FAIL rand_led_out[%0d]: got %h expected %h", k, led_out, m_led);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_ramp();
        logic [31:0] exp_rd [4];
        bit seen;
        exp_rd = '{32'h0, 32'hFF, 32'h01, 32'h00};
        wr(2'd0, 8'h00);
        wr(2'd2, 8'h40);
        wr(2'd1, 8'hFF);
        led_in = 8'hFF;
        wr(2'd0, 8'h03);
        run_n(2 * FRAME);
        seen = 1'b0;
        for (int k = 0; k < FRAME && !seen; k++) begin
            cyc();
            seen = (led_out != 8'h00);
        end
        checks++;
        if (!seen) $display("FAIL ramp_wait_led_on: got 0 expected 1");
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (led_out !== 8'h00) $display("FAIL async_reset_led: got %h expected 00", led_out);
        else passed++;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            checks++;
            if (readdata !== exp_rd[a]) $display("FAIL ramp_reset_read[%0d]: got %h expected %h", a, readdata, exp_rd[a]);
            else passed++;
        end
        acc0 = 0; acc1 = 0;
        run_n(FRAME);
        checks++;
        if (acc0 !== 0 || acc1 !== 0) $display("FAIL post_reset_idle: got %0d/%0d expected 0/0", acc0, acc1);
        else passed++;
    endtask

    initial begin
        acc0 = 0; acc1 = 0;
        test_reset();
        test_static_duty();
        test_fade_up();
        test_fade_down();
        test_mid_frame_bright();
        test_disable();
        test_random();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
